bcd_cascade_counter: RTL and testbench
======================================

Name: bcd_cascade_counter

Overview:
- Parametrised successor to the single-bit toggle flip-flop: a cascade of NUM_DIGITS BCD/modulo-N digit counters, each with its own modulus.
- Forms the stopwatch timebase, for example MM:SS with moduli 6,10,6,10.
- Adds up/down counting, synchronous clear, a lap (display freeze) function, a wrap pulse and a sticky overflow flag.
- Sits between the tick prescaler and the seven-segment display driver.

Parameters:
- NUM_DIGITS, 4: number of cascaded digits (1..8).
- MOD_PATTERN, 32'h00006A6A: packed 4-bit modulus per digit. Nibble i is the modulus of digit i. Default gives digit0=10, digit1=6, digit2=10, digit3=6. Only the low NUM_DIGITS nibbles are used.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- tick, input, 1: count enable; one step per cycle while high.
- up_dn, input, 1: 1 = count up, 0 = count down; sampled only when tick=1.
- clear, input, 1: synchronous clear.
- lap, input, 1: lap request; acts on its rising edge.
- count, output, 4*NUM_DIGITS: live digit values, digit0 in [3:0].
- display, output, 4*NUM_DIGITS: value to show; frozen while lap_active.
- lap_active, output, 1: display is frozen.
- carry_out, output, 1: one-cycle pulse on full-chain wrap.
- overflow, output, 1: sticky; the chain has wrapped since the last clear.

Behaviour:
- Reset (reset=0, asynchronous): all digits=0, lap register=0, lap_active=0, carry_out=0, overflow=0, lap edge-detect register=0. Takes effect immediately, including mid-count or mid-lap.
- Elaboration check: each used nibble of MOD_PATTERN must be 2..10. Any other value is a fatal elaboration error.
- Priority per cycle: clear > tick.
- Clear (clear=1):
  - digits=0, overflow=0, carry_out=0, lap_active=0.
  - tick is ignored in that cycle.
- Up count (tick=1, up_dn=1):
  - digit0 increments.
  - digit i (i>0) steps only when every lower digit j holds MOD_j-1.
  - A stepping digit at MOD_i-1 wraps to 0; otherwise it increments by 1.
- Down count (tick=1, up_dn=0):
  - digit0 decrements.
  - digit i steps only when every lower digit holds 0.
  - A stepping digit at 0 wraps to MOD_i-1; otherwise it decrements by 1.
- Full wrap:
  - Up from all-max to all-zero, or down from all-zero to all-max.
  - carry_out=1 for exactly the next cycle; overflow set to 1 and held until clear or reset.
- No tick: digits hold; carry_out=0.
- Latency: count reflects a tick on the clock edge that samples it (1 cycle). carry_out is registered and coincides with the wrapped count value.
- Lap:
  - Rising edge = lap=1 and previous sampled lap=0. A held level acts once.
  - On a rising edge with lap_active=0: lap register captures count (the pre-update value if tick is also active); lap_active becomes 1.
  - On a rising edge with lap_active=1: lap_active becomes 0.
  - Counting continues while lap_active is high.
- display = lap register when lap_active=1, otherwise count. This is a combinational mux of registered values.
- clear and lap rising edge in the same cycle: clear wins; lap_active=0 and no capture.
- Digit values never leave 0..MOD_i-1 for any input sequence.

Test Plan (all cases use default parameters):
1. Release reset, 9 ticks up -> count=0x0009. 10th tick -> 0x0010. 60th tick total -> 0x0100. display tracks count and carry_out stays 0.
2. Tick up to 0x5959 (3599 ticks), one more tick -> count=0x0000, carry_out high exactly one cycle, overflow=1 and stays 1 over 20 further ticks.
3. From reset, up_dn=0, one tick -> count=0x5959, carry_out pulse, overflow=1. Tick down again -> 0x5958. Tick down from 0x0100 -> 0x0059.
4. At count=0x0012 raise lap with tick active -> display=0x0012, lap_active=1. Hold lap 3 cycles, drop it, then 5 more ticks -> count=0x0017 (plus ticks during the hold), display still 0x0012. Second lap pulse -> lap_active=0, display=count.
5. clear asserted together with tick and a lap edge at count=0x0345, overflow=1 -> next cycle count=0x0000, overflow=0, lap_active=0, carry_out=0.
6. Drive reset low asynchronously between clock edges at count=0x0231 with lap_active=1 -> all outputs 0 immediately. After release, the first tick -> 0x0001.

Source files
------------

// File: rtl/bcd_cascade_counter.sv
// Cascaded modulo-N digit counter for the stopwatch timebase: up/down
// counting, synchronous clear, lap freeze of the display, a full-wrap pulse
// and a sticky overflow flag.
module bcd_cascade_counter #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter logic [31:0] MOD_PATTERN = 32'h00006A6A
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    up_dn,
  input  logic                    clear,
  input  logic                    lap,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic [4*NUM_DIGITS-1:0] display,
  output logic                    lap_active,
  output logic                    carry_out,
  output logic                    overflow
);

  localparam int unsigned DW = 4;
  localparam int unsigned CW = DW * NUM_DIGITS;

  // Reject unsupported digit counts and moduli when the design is elaborated.
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $fatal(1, "bcd_cascade_counter: NUM_DIGITS must be 1..8");
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_mod_chk
    if (MOD_PATTERN[DW*g +: DW] < 4'd2 || MOD_PATTERN[DW*g +: DW] > 4'd10) begin : g_bad_mod
      $fatal(1, "bcd_cascade_counter: digit modulus must be 2..10");
    end
  end

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] lap_reg_q, lap_reg_d;
  logic          lap_active_q, lap_active_d;
  logic          carry_q, carry_d;
  logic          ovf_q, ovf_d;
  logic          lap_prev_q, lap_prev_d;
  logic          lap_rise;
  logic          chain;
  logic [DW-1:0] dig;
  logic [DW-1:0] mod_i;

  assign lap_rise = lap & ~lap_prev_q;

  // Next-state: clear beats tick; each digit steps only while every lower
  // digit sits at its rollover value, and a chain that rolls all the way
  // through is the full wrap.
  always_comb begin
    count_d      = count_q;
    lap_reg_d    = lap_reg_q;
    lap_active_d = lap_active_q;
    carry_d      = 1'b0;
    ovf_d        = ovf_q;
    lap_prev_d   = lap;
    chain        = 1'b1;
    dig          = '0;
    mod_i        = '0;
    if (clear) begin
      count_d      = '0;
      ovf_d        = 1'b0;
      lap_active_d = 1'b0;
    end else begin
      if (tick) begin
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
          dig   = count_q[DW*i +: DW];
          mod_i = MOD_PATTERN[DW*i +: DW];
          if (chain) begin
            if (up_dn) begin
              count_d[DW*i +: DW] = (dig >= mod_i - 4'd1) ? 4'd0 : dig + 4'd1;
            end else begin
              count_d[DW*i +: DW] = (dig == 4'd0 || dig >= mod_i) ? mod_i - 4'd1 : dig - 4'd1;
            end
          end
          chain = chain & (up_dn ? (dig >= mod_i - 4'd1) : (dig == 4'd0));
        end
        if (chain) begin
          carry_d = 1'b1;
          ovf_d   = 1'b1;
        end
      end
      // Lap edge toggles the freeze; capture uses the pre-tick count.
      if (lap_rise) begin
        if (!lap_active_q) begin
          lap_reg_d    = count_q;
          lap_active_d = 1'b1;
        end else begin
          lap_active_d = 1'b0;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q      <= '0;
      lap_reg_q    <= '0;
      lap_active_q <= 1'b0;
      carry_q      <= 1'b0;
      ovf_q        <= 1'b0;
      lap_prev_q   <= 1'b0;
    end else begin
      count_q      <= count_d;
      lap_reg_q    <= lap_reg_d;
      lap_active_q <= lap_active_d;
      carry_q      <= carry_d;
      ovf_q        <= ovf_d;
      lap_prev_q   <= lap_prev_d;
    end
  end

  assign count      = count_q;
  assign display    = lap_active_q ? lap_reg_q : count_q;
  assign lap_active = lap_active_q;
  assign carry_out  = carry_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Self-checking bench for bcd_cascade_counter with default MM:SS moduli.
module tb_bcd_cascade_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic        up_dn;
  logic        clear;
  logic        lap;
  logic [15:0] count;
  logic [15:0] display;
  logic        lap_active;
  logic        carry_out;
  logic        overflow;

  typedef logic [34:0] exp_t;
  exp_t sb_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model: chain value as seconds 0..3599.
  int   m_v;
  int   m_reg;
  logic m_act;
  logic m_ovf;
  logic m_prev;

  bcd_cascade_counter dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .up_dn      (up_dn),
    .clear      (clear),
    .lap        (lap),
    .count      (count),
    .display    (display),
    .lap_active (lap_active),
    .carry_out  (carry_out),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 600) % 6), 4'((v / 60) % 10), 4'((v / 10) % 6), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_v = 0; m_reg = 0; m_act = 1'b0; m_ovf = 1'b0; m_prev = 1'b0;
    sb_q.delete();
  endtask

  // Drive one cycle, push the model's expectation, compare after the edge.
  task automatic cyc(input logic t, input logic u, input logic c, input logic l);
    int   pre;
    logic cy;
    exp_t e;
    tick = t; up_dn = u; clear = c; lap = l;
    pre = m_v;
    cy  = 1'b0;
    if (c) begin
      m_v = 0; m_ovf = 1'b0; m_act = 1'b0;
    end else begin
      if (t) begin
        if (u) begin
          if (m_v == 3599) cy = 1'b1;
          m_v = (m_v + 1) % 3600;
        end else begin
          if (m_v == 0) cy = 1'b1;
          m_v = (m_v + 3599) % 3600;
        end
        if (cy) m_ovf = 1'b1;
      end
      if (l && !m_prev) begin
        if (!m_act) begin
          m_reg = pre;
          m_act = 1'b1;
        end else begin
          m_act = 1'b0;
        end
      end
    end
    m_prev = l;
    e = {to_bcd(m_v), (m_act ? to_bcd(m_reg) : to_bcd(m_v)), m_act, cy, m_ovf};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("cyc", 64'({count, display, lap_active, carry_out, overflow}), 64'(e));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; tick = 1'b0; up_dn = 1'b1; clear = 1'b0; lap = 1'b0;
    model_reset();
    #12;
    chk("reset_state", 64'({count, display, lap_active, carry_out, overflow}), 64'(0));
    @(posedge clk); #1;
    reset = 1'b1;

    // 1: basic up counting through digit boundaries
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t1_nine", 64'(count), 64'(16'h0009));
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t1_ten", 64'(count), 64'(16'h0010));
    for (int i = 0; i < 50; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t1_sixty", 64'(count), 64'(16'h0100));
    chk("t1_disp", 64'(display), 64'(16'h0100));

    // 2: full up wrap, carry pulse, sticky overflow
    for (int i = 0; i < 3600 && m_v != 3599; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t2_max", 64'(count), 64'(16'h5959));
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t2_wrap", 64'({count, carry_out, overflow}), 64'({16'h0000, 1'b1, 1'b1}));
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t2_ovf_held", 64'({carry_out, overflow}), 64'({1'b0, 1'b1}));

    // 3: down counting from zero and across digit boundaries
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_down_wrap", 64'({count, carry_out, overflow}), 64'({16'h5959, 1'b1, 1'b1}));
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_down", 64'(count), 64'(16'h5958));
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 60; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_borrow", 64'(count), 64'(16'h0059));

    // 4: lap freeze while counting continues
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("t4_capture", 64'({display, lap_active}), 64'({16'h0012, 1'b1}));
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t4_frozen", 64'({count, display}), 64'({16'h0021, 16'h0012}));
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("t4_release", 64'({display, lap_active}), 64'({16'h0021, 1'b0}));
    cyc(1'b1, 1'b1, 1'b0, 1'b0);

    // 5: clear beats tick and a lap edge
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 225; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_pre", 64'({count, overflow, lap_active}), 64'({16'h0345, 1'b1, 1'b1}));
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t5_clear", 64'({count, overflow, lap_active, carry_out}), 64'({16'h0000, 4'b0}));
    cyc(1'b0, 1'b1, 1'b0, 1'b0);

    // 6: asynchronous reset mid-cycle with lap active
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 150; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t6_pre", 64'({count, lap_active}), 64'({16'h0231, 1'b1}));
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async", 64'({count, display, lap_active, carry_out, overflow}), 64'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t6_first", 64'(count), 64'(16'h0001));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
